// File: rtl/decoded_inst_queue_pkg.sv
// Shared types for the decode->dispatch instruction queue: the per-entry record
// and the serialization FSM states.
package decoded_inst_queue_pkg;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  code;
  } exception_t;

  localparam logic [4:0] EXC_RI = 5'd10;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] imm;
  } decoded_inst_t;

  typedef struct packed {
    decoded_inst_t inst;
    virt_t         pc;
    exception_t    exc;
    logic          serial;
  } dq_entry_t;

  typedef enum logic [1:0] {DQ_NORMAL, DQ_DRAIN, DQ_ISSUE, DQ_POST} dq_state_t;

endpackage

// File: rtl/decoded_inst_queue_if.sv
// Decode-side enqueue, dispatch-side dequeue and ROB/flush control for the queue.
interface decoded_inst_queue_if import decoded_inst_queue_pkg::*; #(
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic                   flush;
  logic [1:0]             enq_valid;
  decoded_inst_t [1:0]    enq_inst;
  virt_t [1:0]            enq_pc;
  exception_t [1:0]       enq_exc;
  logic [1:0]             enq_serialize;
  logic                   enq_ready;
  logic [1:0]             deq_valid;
  decoded_inst_t [1:0]    deq_inst;
  virt_t [1:0]            deq_pc;
  exception_t [1:0]       deq_exc;
  logic [1:0]             deq_ready;
  logic                   rob_empty;
  logic [PTR_W:0]         count;

  modport master (
    output flush, enq_valid, enq_inst, enq_pc, enq_exc, enq_serialize, deq_ready, rob_empty,
    input  enq_ready, deq_valid, deq_inst, deq_pc, deq_exc, count
  );

  modport slave (
    input  flush, enq_valid, enq_inst, enq_pc, enq_exc, enq_serialize, deq_ready, rob_empty,
    output enq_ready, deq_valid, deq_inst, deq_pc, deq_exc, count
  );
endinterface

// File: rtl/decoded_inst_queue.sv
// Dual-lane circular queue between decode and dispatch; privileged/ERET/excepting
// entries are issued alone against an empty ROB and block younger entries until committed.
module decoded_inst_queue import decoded_inst_queue_pkg::*; #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  decoded_inst_queue_if.slave  dq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  dq_entry_t mem_q [DEPTH];
  dq_entry_t mem_d [DEPTH];
  ptr_t      head_q, head_d, tail_q, tail_d, head_p1, tail_w1;
  cnt_t      count_q, count_d;
  dq_state_t state_q, state_d;

  logic       has0, has1, head_serial, next_serial, hs0, hs1, enq_ok;
  logic [1:0] n_enq, n_deq;

  assign head_p1     = head_q + ptr_t'(1);
  assign has0        = count_q != '0;
  assign has1        = count_q >= cnt_t'(2);
  assign head_serial = mem_q[head_q].serial;
  assign next_serial = mem_q[head_p1].serial;
  assign enq_ok      = count_q <= cnt_t'(DEPTH - 2);

  assign dq.enq_ready   = enq_ok;
  assign dq.count       = count_q;
  assign dq.deq_inst[0] = mem_q[head_q].inst;
  assign dq.deq_inst[1] = mem_q[head_p1].inst;
  assign dq.deq_pc[0]   = mem_q[head_q].pc;
  assign dq.deq_pc[1]   = mem_q[head_p1].pc;
  assign dq.deq_exc[0]  = mem_q[head_q].exc;
  assign dq.deq_exc[1]  = mem_q[head_p1].exc;

  always_comb begin
    dq.deq_valid = '0;
    state_d      = state_q;
    unique case (state_q)
      DQ_NORMAL: begin
        dq.deq_valid[0] = has0 & ~head_serial;
        dq.deq_valid[1] = has1 & ~head_serial & ~next_serial;
        if (has0 && head_serial) state_d = dq.rob_empty ? DQ_ISSUE : DQ_DRAIN;
      end
      DQ_DRAIN: if (dq.rob_empty) state_d = DQ_ISSUE;
      DQ_ISSUE: begin
        dq.deq_valid[0] = has0;
        if (has0 && dq.deq_ready[0]) state_d = DQ_POST;
      end
      // The ROB only sees the serial entry after the handshake edge, so rob_empty is
      // trusted from the cycle after issue onwards.
      DQ_POST: if (dq.rob_empty) state_d = DQ_NORMAL;
      default: state_d = DQ_NORMAL;
    endcase

    hs0   = dq.deq_valid[0] & dq.deq_ready[0];
    hs1   = hs0 & dq.deq_valid[1] & dq.deq_ready[1];
    n_deq = {1'b0, hs0} + {1'b0, hs1};
    n_enq = enq_ok ? ({1'b0, dq.enq_valid[0]} + {1'b0, dq.enq_valid[1]}) : 2'd0;

    // Valid lanes are compacted: lane1 lands at tail when lane0 is idle.
    tail_w1 = tail_q + ptr_t'(dq.enq_valid[0]);
    mem_d   = mem_q;
    head_d  = head_q + ptr_t'(n_deq);
    tail_d  = tail_q + ptr_t'(n_enq);
    count_d = count_q + cnt_t'(n_enq) - cnt_t'(n_deq);

    if (dq.flush) begin
      state_d = DQ_NORMAL;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (enq_ok) begin
      if (dq.enq_valid[0])
        mem_d[tail_q]  = '{inst: dq.enq_inst[0], pc: dq.enq_pc[0], exc: dq.enq_exc[0],
                           serial: dq.enq_serialize[0] | dq.enq_exc[0].ex};
      if (dq.enq_valid[1])
        mem_d[tail_w1] = '{inst: dq.enq_inst[1], pc: dq.enq_pc[1], exc: dq.enq_exc[1],
                           serial: dq.enq_serialize[1] | dq.enq_exc[1].ex};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= DQ_NORMAL;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: tb/tb_decoded_inst_queue.sv
// Directed bench for decoded_inst_queue: queue-based reference model compared every
// cycle, plus literal expectations on the directed scenarios.
module tb_decoded_inst_queue;
  import decoded_inst_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  decoded_inst_queue_if #(.DEPTH(DEPTH)) dq ();
  decoded_inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .dq(dq));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of entries plus a blocking phase
  // (0 free, 1 waiting ROB empty, 2 serial entry offered, 3 waiting commit).
  dq_entry_t mq[$];
  int        mphase   = 0;
  bit        mstarted = 1'b0;

  function automatic logic [1:0] m_valid();
    logic [1:0] v;
    v = 2'b00;
    if (mq.size() > 0) begin
      if (mphase == 0 && !mq[0].serial) begin
        v[0] = 1'b1;
        v[1] = (mq.size() > 1) && !mq[1].serial;
      end else if (mphase == 2) begin
        v[0] = 1'b1;
      end
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!resetn || dq.flush) begin
      mq.delete();
      mphase = 0;
      if (!resetn) mstarted = 1'b1;
    end else begin
      logic [1:0] v;
      bit h0, h1;
      int sz;
      v  = m_valid();
      sz = mq.size();
      h0 = v[0] && dq.deq_ready[0];
      h1 = v[1] && dq.deq_ready[1] && h0;
      case (mphase)
        0: if (sz > 0 && mq[0].serial) mphase = dq.rob_empty ? 2 : 1;
        1: if (dq.rob_empty) mphase = 2;
        2: if (h0) mphase = 3;
        3: if (dq.rob_empty) mphase = 0;
        default: mphase = 0;
      endcase
      if (h0) void'(mq.pop_front());
      if (h1) void'(mq.pop_front());
      if (sz <= int'(DEPTH) - 2)
        for (int l = 0; l < 2; l++)
          if (dq.enq_valid[l])
            mq.push_back('{inst: dq.enq_inst[l], pc: dq.enq_pc[l], exc: dq.enq_exc[l],
                           serial: dq.enq_serialize[l] | dq.enq_exc[l].ex});
    end
  end

  always @(negedge clk) begin
    if (mstarted && resetn) begin
      logic [1:0] v;
      v = m_valid();
      check("count", 64'(dq.count), 64'(mq.size()));
      check("enq_ready", 64'(dq.enq_ready), 64'(mq.size() <= int'(DEPTH) - 2));
      check("deq_valid", 64'(dq.deq_valid), 64'(v));
      for (int l = 0; l < 2; l++)
        if (v[l]) begin
          check($sformatf("deq_pc%0d", l), 64'(dq.deq_pc[l]), 64'(mq[l].pc));
          check($sformatf("deq_inst%0d", l), 64'(dq.deq_inst[l]), 64'(mq[l].inst));
          check($sformatf("deq_exc%0d", l), 64'(dq.deq_exc[l]), 64'(mq[l].exc));
        end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dq.enq_valid     = 2'b00;
    dq.enq_serialize = 2'b00;
    dq.enq_exc       = '0;
  endtask

  task automatic put(input int l, input logic [31:0] pc, input bit ser, input bit ex);
    dq.enq_valid[l]        = 1'b1;
    dq.enq_pc[l]           = pc;
    dq.enq_inst[l].opcode  = pc[9:2];
    dq.enq_inst[l].rd      = pc[4:0];
    dq.enq_inst[l].imm     = ~pc;
    dq.enq_serialize[l]    = ser;
    dq.enq_exc[l].ex       = ex;
    dq.enq_exc[l].code     = ex ? EXC_RI : 5'd0;
  endtask

  initial begin
    dq.flush     = 1'b0;
    dq.enq_inst  = '0;
    dq.enq_pc    = '0;
    dq.deq_ready = 2'b00;
    dq.rob_empty = 1'b1;
    idle();

    // Reset, then a dual enqueue consumed the next cycle
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    check("rst_count", 64'(dq.count), 64'd0);
    check("rst_deq_valid", 64'(dq.deq_valid), 64'd0);
    check("rst_enq_ready", 64'(dq.enq_ready), 64'd1);
    put(0, 32'h100, 0, 0); put(1, 32'h104, 0, 0);
    dq.deq_ready = 2'b11;
    cyc();
    idle();
    check("dual_valid", 64'(dq.deq_valid), 64'h3);
    check("dual_pc0", 64'(dq.deq_pc[0]), 64'h100);
    check("dual_pc1", 64'(dq.deq_pc[1]), 64'h104);
    cyc();
    check("dual_count_after", 64'(dq.count), 64'd0);
    check("dual_valid_after", 64'(dq.deq_valid), 64'd0);

    // Fill to 7, extra enqueue ignored, drain one per cycle across the wrap
    dq.deq_ready = 2'b00;
    put(0, 32'h300, 0, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      idle();
      put(0, 32'h304 + 32'(8 * k), 0, 0); put(1, 32'h308 + 32'(8 * k), 0, 0);
      cyc();
    end
    idle();
    check("fill_count", 64'(dq.count), 64'd7);
    check("fill_enq_ready", 64'(dq.enq_ready), 64'd0);
    put(0, 32'h400, 0, 0); put(1, 32'h404, 0, 0);
    cyc();
    idle();
    check("full_ignored_count", 64'(dq.count), 64'd7);
    dq.deq_ready = 2'b01;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("drain_pc_%0d", i), 64'(dq.deq_pc[0]), 64'h300 + 64'(4 * i));
      cyc();
    end
    check("drain_count", 64'(dq.count), 64'd0);

    // Lane1-only enqueue lands at tail and is offered on lane0
    dq.deq_ready = 2'b00;
    put(1, 32'h200, 0, 0);
    cyc();
    idle();
    check("l1_count", 64'(dq.count), 64'd1);
    check("l1_valid", 64'(dq.deq_valid), 64'h1);
    check("l1_pc", 64'(dq.deq_pc[0]), 64'h200);
    dq.deq_ready = 2'b01;
    cyc();

    // ERET at head with a busy ROB
    put(0, 32'h500, 1, 0); put(1, 32'h504, 0, 0);
    dq.rob_empty = 1'b0;
    dq.deq_ready = 2'b11;
    cyc();
    idle();
    check("eret_blocked", 64'(dq.deq_valid), 64'h0);
    cyc();
    check("eret_drain", 64'(dq.deq_valid), 64'h0);
    dq.rob_empty = 1'b1;
    cyc();
    check("eret_issue_valid", 64'(dq.deq_valid), 64'h1);
    check("eret_issue_pc", 64'(dq.deq_pc[0]), 64'h500);
    dq.deq_ready = 2'b01;
    cyc();
    check("eret_post_valid", 64'(dq.deq_valid), 64'h0);
    check("eret_post_count", 64'(dq.count), 64'd1);
    dq.rob_empty = 1'b0;
    cyc();
    check("eret_post_hold", 64'(dq.deq_valid), 64'h0);
    put(0, 32'h508, 0, 0);
    dq.rob_empty = 1'b1;
    dq.deq_ready = 2'b00;
    cyc();
    idle();
    check("eret_resume_valid", 64'(dq.deq_valid), 64'h3);
    check("eret_resume_pc1", 64'(dq.deq_pc[1]), 64'h508);
    dq.deq_ready = 2'b11;
    cyc();

    // Excepting entry at head+1 is not paired with head
    dq.deq_ready = 2'b00;
    put(0, 32'h600, 0, 0); put(1, 32'h604, 0, 1);
    cyc();
    idle();
    check("exc_pair_valid", 64'(dq.deq_valid), 64'h1);
    dq.deq_ready = 2'b01;
    cyc();
    check("exc_head_blocked", 64'(dq.deq_valid), 64'h0);
    cyc();
    check("exc_issue_valid", 64'(dq.deq_valid), 64'h1);
    check("exc_issue_ex", 64'(dq.deq_exc[0]), 64'({1'b1, EXC_RI}));
    cyc();
    check("exc_post_count", 64'(dq.count), 64'd0);
    cyc();

    // Flush with count=5 while enqueue and dequeue are both active
    dq.deq_ready = 2'b00;
    put(0, 32'h900, 0, 0); put(1, 32'h904, 0, 0); cyc();
    put(0, 32'h908, 0, 0); put(1, 32'h90c, 0, 0); cyc();
    idle();
    put(0, 32'h910, 0, 0); cyc();
    idle();
    check("pre_flush_count", 64'(dq.count), 64'd5);
    dq.flush = 1'b1;
    put(0, 32'ha00, 0, 0); put(1, 32'ha04, 0, 0);
    dq.deq_ready = 2'b11;
    cyc();
    dq.flush = 1'b0;
    idle();
    check("flush_count", 64'(dq.count), 64'd0);
    check("flush_valid", 64'(dq.deq_valid), 64'h0);
    dq.deq_ready = 2'b00;
    put(0, 32'h700, 0, 0);
    cyc();
    idle();
    check("post_flush_pc", 64'(dq.deq_pc[0]), 64'h700);
    dq.deq_ready = 2'b01;
    cyc();

    // Reset while draining for a serial entry
    dq.deq_ready = 2'b00;
    dq.rob_empty = 1'b0;
    put(0, 32'h710, 1, 0);
    cyc();
    idle();
    cyc();
    check("drain_before_rst", 64'(dq.deq_valid), 64'h0);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    check("rst2_count", 64'(dq.count), 64'd0);
    check("rst2_valid", 64'(dq.deq_valid), 64'h0);
    put(0, 32'h800, 0, 0);
    cyc();
    idle();
    check("rst2_normal_valid", 64'(dq.deq_valid), 64'h1);
    dq.deq_ready = 2'b01;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
